pc_sequencer: RTL and testbench

- Program-counter controller for the 3BC processor.
- Launches a program on a Start request, advances the PC each retired instruction, and resolves taken branches by adding the signed relative offset returned by the branch-target lookup table.
- Detects halt and out-of-range targets, and keeps retired-instruction and taken-branch counters.
- Sits between the instruction decoder, the target LUT (combinational, 4-bit index in, 11-bit signed offset out) and instruction memory.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter controller for the 3BC processor: launches a program,
// steps the PC per retired instruction, resolves taken relative branches via
// the target LUT, and flags halt / out-of-range targets with statistics.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for Start
// LAUNCH  | one-cycle fetch latency, PC already at ProgBase
// RUN     | executing; PC advances or branches each non-stalled cycle
// HALTED  | halt retired; PC/counters frozen until Start
// FAULT   | PC would leave the address space; frozen until Start
module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 11,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  ProgBase,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchCond,
    input  logic             HaltReq,
    input  logic [IDX_W-1:0] LutIdx,
    output logic [IDX_W-1:0] LutIdxOut,
    input  logic [OFF_W-1:0] LutOffset,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] BranchCount
);

    // Two extra bits hold both a negative result and a carry past the top
    // address; the offset must fit inside that width.
    localparam int T_W = PC_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t                 state;
    logic signed [T_W-1:0]  target;
    logic                   target_ok;
    logic                   pc_at_top;
    logic [CNT_W-1:0]       instr_next;
    logic [CNT_W-1:0]       branch_next;

    // The LUT lookup is purely combinational, so the index passes straight through.
    assign LutIdxOut = LutIdx;

    // Branch target, range check and saturating counter increments.
    always_comb begin
        target      = $signed({2'b00, PC}) + T_W'($signed(LutOffset));
        target_ok   = (target[T_W-1:PC_W] == '0);
        pc_at_top   = &PC;
        instr_next  = (&InstrCount)  ? InstrCount  : InstrCount  + CNT_W'(1);
        branch_next = (&BranchCount) ? BranchCount : BranchCount + CNT_W'(1);
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            PC          <= '0;
            Running     <= 1'b0;
            Done        <= 1'b0;
            Fault       <= 1'b0;
            InstrCount  <= '0;
            BranchCount <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (Start) begin
                        state       <= S_LAUNCH;
                        PC          <= ProgBase;
                        InstrCount  <= '0;
                        BranchCount <= '0;
                        Running     <= 1'b1;
                        Done        <= 1'b0;
                        Fault       <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (Stall) begin
                        state <= S_RUN;
                    end else if (HaltReq) begin
                        // Halt wins over a simultaneous branch.
                        state      <= S_HALTED;
                        InstrCount <= instr_next;
                        Running    <= 1'b0;
                        Done       <= 1'b1;
                    end else if (BranchEn && BranchCond) begin
                        InstrCount <= instr_next;
                        if (target_ok) begin
                            PC          <= target[PC_W-1:0];
                            BranchCount <= branch_next;
                        end else begin
                            state   <= S_FAULT;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                            Fault   <= 1'b1;
                        end
                    end else begin
                        InstrCount <= instr_next;
                        if (pc_at_top) begin
                            // Falling off the end of memory is a fault, never a wrap.
                            state   <= S_FAULT;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                            Fault   <= 1'b1;
                        end else begin
                            PC <= PC + PC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int OFF_W = 11;
    localparam int IDX_W = 4;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Reset, Start, Stall, BranchEn, BranchCond, HaltReq;
    logic [PC_W-1:0]  ProgBase;
    logic [IDX_W-1:0] LutIdx, LutIdxOut;
    logic [OFF_W-1:0] LutOffset;
    logic [PC_W-1:0]  PC;
    logic             Running, Done, Fault;
    logic [CNT_W-1:0] InstrCount, BranchCount;

    int n_checks = 0;
    int n_pass   = 0;

    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgBase(ProgBase),
        .Stall(Stall), .BranchEn(BranchEn), .BranchCond(BranchCond),
        .HaltReq(HaltReq), .LutIdx(LutIdx), .LutIdxOut(LutIdxOut),
        .LutOffset(LutOffset), .PC(PC), .Running(Running), .Done(Done),
        .Fault(Fault), .InstrCount(InstrCount), .BranchCount(BranchCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic expect_status(input string tag, input int pc, input logic run,
                                 input logic done, input logic fault,
                                 input int ic, input int bc);
        check({tag, ".pc"},      PC, pc);
        check({tag, ".running"}, Running, run);
        check({tag, ".done"},    Done, done);
        check({tag, ".fault"},   Fault, fault);
        check({tag, ".icount"},  InstrCount, ic);
        check({tag, ".bcount"},  BranchCount, bc);
    endtask

    task automatic branch(input logic en, input logic cond, input int off);
        BranchEn   = en;
        BranchCond = cond;
        LutOffset  = OFF_W'(off);
    endtask

    task automatic check_lut(input string tag, input logic [IDX_W-1:0] v);
        LutIdx = v;
        #1;
        check(tag, LutIdxOut, v);
    endtask

    task automatic launch(input int base);
        Start = 1'b1; ProgBase = PC_W'(base);
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; HaltReq = 1'b0;
        BranchEn = 1'b0; BranchCond = 1'b0; ProgBase = '0;
        LutIdx = '0; LutOffset = '0;

        // 1. reset, launch at 100, three RUN cycles
        tick(2);
        expect_status("reset", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        check_lut("lut_idle", 4'd9);
        tick();
        expect_status("idle_hold", 0, 0, 0, 0, 0, 0);
        launch(100);
        expect_status("launch100", 100, 1, 0, 0, 0, 0);
        tick();
        check("run_entry.pc", PC, 100);
        tick(3);
        expect_status("run3", 103, 1, 0, 0, 3, 0);
        check_lut("lut_run", 4'd6);

        // 2. branch from 400 with offset -370, back, then not-taken
        Reset = 1'b1; tick(); Reset = 1'b0;
        launch(400); tick();
        check("at400.pc", PC, 400);
        branch(1, 1, -370); tick();
        expect_status("br_taken", 30, 1, 0, 0, 1, 1);
        branch(1, 1, 370); tick();
        expect_status("br_back", 400, 1, 0, 0, 2, 2);
        branch(1, 0, -370); tick();
        expect_status("br_not_taken", 401, 1, 0, 0, 3, 2);

        // 3. stall at 200 with halt and branch pending, then halt wins
        branch(1, 1, -201); tick();
        expect_status("to200", 200, 1, 0, 0, 4, 3);
        Stall = 1'b1; HaltReq = 1'b1; branch(1, 1, 5);
        tick(3);
        expect_status("stalled", 200, 1, 0, 0, 4, 3);
        Stall = 1'b0; tick();
        expect_status("halt_over_branch", 200, 0, 1, 0, 5, 3);
        HaltReq = 1'b0; branch(0, 0, 0);
        tick(2);
        expect_status("halted_hold", 200, 0, 1, 0, 5, 3);
        check_lut("lut_halted", 4'd15);

        // 4. 20 instructions from 30, halt at 50, relaunch at 0
        launch(30);
        expect_status("launch30", 30, 1, 0, 0, 0, 0);
        tick(21);
        expect_status("after20", 50, 1, 0, 0, 20, 0);
        HaltReq = 1'b1; tick(); HaltReq = 1'b0;
        expect_status("halt50", 50, 0, 1, 0, 21, 0);
        launch(0);
        expect_status("relaunch0", 0, 1, 0, 0, 0, 0);

        // 5. fault on negative target, then fault at the top address
        tick();
        branch(1, 1, 10); tick();
        expect_status("to10", 10, 1, 0, 0, 1, 1);
        branch(1, 1, -445); tick();
        expect_status("fault_neg", 10, 0, 1, 1, 2, 1);
        branch(0, 0, 0);
        tick();
        expect_status("fault_hold", 10, 0, 1, 1, 2, 1);
        check_lut("lut_fault", 4'd3);
        launch(1020);
        expect_status("recover1020", 1020, 1, 0, 0, 0, 0);
        tick(4);
        expect_status("at1023", 1023, 1, 0, 0, 3, 0);
        tick();
        expect_status("fault_top", 1023, 0, 1, 1, 4, 0);
        launch(1000);
        tick();
        branch(1, 1, 100); tick(); branch(0, 0, 0);
        expect_status("fault_over", 1000, 0, 1, 1, 1, 0);
        launch(300);
        expect_status("recover300", 300, 1, 0, 0, 0, 0);

        // 6. Start ignored in RUN, reset mid-run
        tick();
        Start = 1'b1; ProgBase = PC_W'(5);
        tick(2);
        Start = 1'b0;
        expect_status("start_ignored", 302, 1, 0, 0, 2, 0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        expect_status("reset_midrun", 0, 0, 0, 0, 0, 0);
        tick();
        check("idle_after_reset.pc", PC, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
